// File: rtl/sort_pkg.sv
// sort_pkg: shared index width, sorter FSM states and active-low {g,f,e,d,c,b,a} hex segment codes
package sort_pkg;
  localparam int IDXW = 4;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational decoder, hex[3:0] in, active-low seg[6:0] {g,f,e,d,c,b,a} out
module hex_to_seg7
  import sort_pkg::*;
(
  input  logic [IDXW-1:0] hex,
  output logic [6:0]      seg
);
  assign seg = SEG_HEX[hex];
endmodule

// File: rtl/param_sort_argmax.sv
// param_sort_argmax: odd-even transposition sorter (clk,rst,data,load,order in; busy,complete,index,data_out,idx_out,display out)
module param_sort_argmax
  import sort_pkg::*;
#(
  parameter int N = 10,
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    data,
  input  logic              load,
  input  logic              order,
  output logic              busy,
  output logic              complete,
  output logic [IDXW-1:0]   index,
  output logic [N*W-1:0]    data_out,
  output logic [N*IDXW-1:0] idx_out,
  output logic [6:0]        display
);
  localparam int PW = $clog2(N + 1);
  state_t state;
  logic [PW-1:0] phase;
  logic desc;
  logic signed [W-1:0] v [N];
  logic signed [W-1:0] nv [N];
  logic [IDXW-1:0] t [N];
  logic [IDXW-1:0] nt [N];
  logic [N-2:0] sw;
  logic [6:0] seg;
  logic accept;
  assign accept = load && ((state == IDLE && !busy) || state == DONE);
  for (genvar p = 0; p < N - 1; p++) begin : g_pair
    assign sw[p] = (phase[0] == 1'(p % 2)) && (desc ? v[p] < v[p+1] : v[p] > v[p+1]);
  end
  for (genvar i = 0; i < N; i++) begin : g_elem
    if (i == 0) begin : g_first
      assign nv[i] = sw[i] ? v[i+1] : v[i];
      assign nt[i] = sw[i] ? t[i+1] : t[i];
    end else if (i == N - 1) begin : g_last
      assign nv[i] = sw[i-1] ? v[i-1] : v[i];
      assign nt[i] = sw[i-1] ? t[i-1] : t[i];
    end else begin : g_mid
      assign nv[i] = sw[i] ? v[i+1] : sw[i-1] ? v[i-1] : v[i];
      assign nt[i] = sw[i] ? t[i+1] : sw[i-1] ? t[i-1] : t[i];
    end
  end
  hex_to_seg7 u_seg (.hex(t[0]), .seg(seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      complete <= 1'b0;
      index    <= '0;
      data_out <= '0;
      idx_out  <= '0;
      display  <= SEG_BLANK;
      phase    <= '0;
      desc     <= 1'b0;
    end else begin
      complete <= state == DONE;
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          v[i] <= data[W*i +: W];
          t[i] <= IDXW'(i);
        end
        desc  <= order;
        phase <= '0;
      end
      case (state)
        IDLE: begin
          busy  <= accept;
          state <= accept ? SORT : IDLE;
        end
        SORT: begin
          v     <= nv;
          t     <= nt;
          phase <= phase + 1'b1;
          if (phase == PW'(N - 1)) state <= DONE;
        end
        default: begin
          for (int k = 0; k < N; k++) begin
            data_out[W*k +: W]       <= v[k];
            idx_out[IDXW*k +: IDXW] <= t[k];
          end
          index   <= t[0];
          display <= seg;
          busy    <= 1'b1;
          state   <= load ? SORT : IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_param_sort_argmax.sv
// tb_param_sort_argmax: directed plus random checks of param_sort_argmax against a selection-sort reference
module tb_param_sort_argmax;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic l10 = 1'b0, o10 = 1'b0, b10, c10;
  logic [159:0] d10 = '0, q10;
  logic [39:0] i10;
  logic [3:0] x10;
  logic [6:0] s10;
  logic l16 = 1'b0, o16 = 1'b0, b16, c16;
  logic [127:0] d16 = '0, q16;
  logic [63:0] i16;
  logic [3:0] x16;
  logic [6:0] s16;
  int checks = 0, passes = 0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  param_sort_argmax #(.N(10), .W(16)) dut10 (
    .clk(clk), .rst(rst), .data(d10), .load(l10), .order(o10), .busy(b10), .complete(c10),
    .index(x10), .data_out(q10), .idx_out(i10), .display(s10));
  param_sort_argmax #(.N(16), .W(8)) dut16 (
    .clk(clk), .rst(rst), .data(d16), .load(l16), .order(o16), .busy(b16), .complete(c16),
    .index(x16), .data_out(q16), .idx_out(i16), .display(s16));
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  // stable selection sort: each slot takes the extreme unused value, lowest index on ties
  task automatic model(input int n, input int w, input logic [255:0] d, input bit ord,
                       output logic [255:0] eo, output logic [63:0] io, output int ex);
    int val [16];
    bit used [16];
    logic [31:0] x;
    logic [255:0] mask;
    int best;
    mask = (256'(1) << w) - 1;
    eo = '0;
    io = '0;
    ex = 0;
    for (int i = 0; i < n; i++) begin
      x = 32'(d >> (w * i));
      x = x << (32 - w);
      val[i] = $signed(x) >>> (32 - w);
      used[i] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || (ord ? val[i] > val[best] : val[i] < val[best]))) best = i;
      used[best] = 1'b1;
      if (k == 0) ex = best;
      eo = eo | ((256'(val[best]) & mask) << (w * k));
      io = io | (64'(best) << (4 * k));
    end
  endtask
  task automatic run10(input logic [159:0] d, input bit o, output int lat, output bit bok);
    @(negedge clk);
    d10 = d; o10 = o; l10 = 1'b1;
    @(negedge clk);
    l10 = 1'b0;
    lat = -1;
    bok = b10;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      bok = bok & b10;
      if (c10) begin lat = j; break; end
    end
  endtask
  task automatic run16(input logic [127:0] d, input bit o, output int lat);
    @(negedge clk);
    d16 = d; o16 = o; l16 = 1'b1;
    @(negedge clk);
    l16 = 1'b0;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (c16) begin lat = j; break; end
    end
  endtask
  logic [159:0] da, dt, db;
  logic [127:0] dr;
  logic [255:0] eo;
  logic [63:0] io;
  int ex, lat, cnt, first, pos1, pos2;
  bit bok, bgap, o;
  initial begin
    da = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;
    repeat (3) @(negedge clk);
    check("rst_busy", b10, 0);
    check("rst_complete", c10, 0);
    check("rst_index", x10, 0);
    check("rst_data_out", q10, 0);
    check("rst_idx_out", i10, 0);
    check("rst_display", s10, 7'h7F);
    check("rst_display16", s16, 7'h7F);
    rst = 1'b0;
    run10(da, 1'b1, lat, bok);
    model(10, 16, 256'(da), 1'b1, eo, io, ex);
    check("desc_latency", lat, 11);
    check("desc_busy", bok, 1);
    check("desc_data", q10, 160'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009);
    check("desc_data_model", q10, eo[159:0]);
    check("desc_idx_model", i10, io[39:0]);
    check("desc_index", x10, 4);
    check("desc_display", s10, 7'b0011001);
    run10(da, 1'b0, lat, bok);
    model(10, 16, 256'(da), 1'b0, eo, io, ex);
    check("asc_latency", lat, 11);
    check("asc_slot0", q10[15:0], 0);
    check("asc_data_model", q10, eo[159:0]);
    check("asc_index", x10, 6);
    check("asc_display", s10, 7'b0000010);
    check("asc_idx_slot9", i10[39:36], 4);
    for (int i = 0; i < 10; i++) dt[16*i +: 16] = (i == 3) ? 16'hFFFF : 16'h0005;
    run10(dt, 1'b1, lat, bok);
    check("tie_index", x10, 0);
    check("tie_idx_out", i10, 40'h3987654210);
    check("tie_slot9", q10[159:144], 16'hFFFF);
    @(negedge clk);
    check("tie_pulse_low", c10, 0);
    for (int i = 0; i < 10; i++) db[16*i +: 16] = 16'($urandom_range(0, 65535));
    @(negedge clk);
    d10 = da; o10 = 1'b1; l10 = 1'b1;
    @(negedge clk);
    l10 = 1'b0;
    cnt = 0; first = -1; bgap = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      if (j == 3) begin d10 = db; o10 = 1'b0; l10 = 1'b1; end
      if (j == 4) l10 = 1'b0;
      @(negedge clk);
      if (c10) begin cnt++; if (first < 0) first = j; end
      if (!b10 && (first < 0 || first == j)) bgap = 1'b1;
    end
    model(10, 16, 256'(da), 1'b1, eo, io, ex);
    check("busy_ignore_count", cnt, 1);
    check("busy_ignore_latency", first, 11);
    check("busy_continuous", bgap, 0);
    check("busy_ignore_data", q10, eo[159:0]);
    @(negedge clk);
    d10 = db; o10 = 1'b1; l10 = 1'b1;
    @(negedge clk);
    l10 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", b10, 0);
    check("abort_complete", c10, 0);
    check("abort_index", x10, 0);
    check("abort_data_out", q10, 0);
    check("abort_idx_out", i10, 0);
    check("abort_display", s10, 7'h7F);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (c10) cnt++;
    end
    check("abort_no_complete", cnt, 0);
    run10(db, 1'b0, lat, bok);
    model(10, 16, 256'(db), 1'b0, eo, io, ex);
    check("after_abort_latency", lat, 11);
    check("after_abort_data", q10, eo[159:0]);
    check("after_abort_idx", i10, io[39:0]);
    @(negedge clk);
    d10 = da; o10 = 1'b1; l10 = 1'b1;
    @(negedge clk);
    d10 = db; o10 = 1'b0;
    pos1 = -1; pos2 = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (c10 && pos1 < 0) begin
        pos1 = j;
        l10 = 1'b0;
        model(10, 16, 256'(da), 1'b1, eo, io, ex);
        check("b2b_first_data", q10, eo[159:0]);
      end else if (c10 && pos2 < 0) pos2 = j;
    end
    l10 = 1'b0;
    model(10, 16, 256'(db), 1'b0, eo, io, ex);
    check("b2b_first_pos", pos1, 11);
    check("b2b_second_pos", pos2, 22);
    check("b2b_second_data", q10, eo[159:0]);
    check("b2b_second_idx", i10, io[39:0]);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        dr[8*i +: 8] = (r % 2 == 1) ? 8'($urandom_range(0, 3) * 8'h55) : 8'($urandom_range(0, 255));
      o = 1'($urandom_range(0, 1));
      run16(dr, o, lat);
      model(16, 8, 256'(dr), o, eo, io, ex);
      check("n16_latency", lat, 17);
      check("n16_data", q16, eo[127:0]);
      check("n16_idx", i16, io);
      check("n16_index", x16, ex);
      check("n16_display", s16, seg_tab[ex]);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/param_sort_argmax.md
# param_sort_argmax

Parametrised sequential sorter for N signed W-bit words with runtime-selectable order. It returns the fully sorted vector, the original index of every output slot, the original index of the extreme element (max or min), and a hex 7-segment rendering of that index. It succeeds the fixed 10×16 sort/display top and sits between the classifier output scores and the board display.

## Interface

**Parameters**
- `N`, default 10: number of elements, legal range 2..16.
- `W`, default 16: element width; elements are signed two's complement.

**Ports**
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in N*W: packed inputs; element i at `[W*i +: W]`, element 0 in the LSBs.
- `load` in 1: start request. Sampled only when not busy.
- `order` in 1: sort order, sampled with an accepted `load`. 1 = descending, 0 = ascending.
- `busy` out 1: a sort is in progress.
- `complete` out 1: one-cycle pulse when the results update.
- `index` out 4: original index of `data_out` slot 0, i.e. argmax (descending) or argmin (ascending).
- `data_out` out N*W: sorted vector; slot 0 holds the extreme value.
- `idx_out` out N*4: original index of each slot; slot k at `[4*k +: 4]`.
- `display` out 7: active-low segments {g,f,e,d,c,b,a} showing `index` as hex 0..F.

## Operation
- FSM states: IDLE, SORT, DONE.
  - IDLE: on `load`, capture `data`, tag element i with index i, latch `order`, clear phase counter, then go to SORT.
  - SORT: one odd-even transposition phase per cycle. Even phases compare pairs (0,1),(2,3),…; odd phases compare pairs (1,2),(3,4),…. Swap a value together with its tag only when the pair is strictly out of order (signed compare). Once N phases are done, go to DONE.
  - DONE: register the working array into `data_out`/`idx_out`, set `index` to the slot-0 tag, and pulse `complete`. The next state is IDLE, or SORT if `load` is high in this cycle (back-to-back accepted).
- Strict-compare swapping makes the sort stable: equal values keep their original relative order. As a result, `index` is the lowest original index among tied extremes.
- `load` is ignored while in SORT. `data` and `order` are not required to be stable after the accept edge.
- Outputs hold their last result until the next DONE. Working registers are not visible at the outputs.
- The phase counter is ceil(log2(N+1)) bits wide and runs 0..N-1. No wrap is needed.

## Timing
- Reset values:
  - `busy`=0, `complete`=0, `index`=0, `data_out`=0, `idx_out`=0.
  - `display`=7'h7F (blank) until the first `complete`.
  - State is IDLE.
- Latency: `load` is accepted at edge k. Phases execute at edges k+1..k+N. Outputs update and `complete`=1 at edge k+N+1, so `complete` is high during the cycle after that edge.
- `busy` is high from edge k through the cycle in which `complete` is high, and low in IDLE.
- `display` is registered from the new `index` and updates on the same edge as `index`.
- When `rst` is asserted mid-SORT, the sort is aborted at that edge and all outputs return to their reset values. No `complete` is produced for the aborted sort.
- When `rst` and `load` are high together, `rst` wins.
- Throughput: one sort per N+1 cycles when `load` is held high continuously.

## Structure
- Package `sort_pkg` holds:
  - `IDXW` = 4.
  - The state enum `{IDLE, SORT, DONE}`.
  - The active-low seven-segment constants for hex 0..F, plus `SEG_BLANK`.
- Sub-module `hex_to_seg7`: a combinational 4-bit to 7-bit decoder whose output is registered in the parent.
- The compare-swap network is a generate loop over the pair index. A separate module is not warranted.

## Test plan
- **Mixed descending.** N=10, W=16, `data`=160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004, `order`=1. Expect:
  - `complete` exactly N+1=11 edges after accept.
  - `data_out` = 160'h0000_0001_…_0009 (slot 0 = 9).
  - `index`=4 and `display`=7'b0011001.
- **Same data ascending.** `order`=0. Expect `data_out` slot 0 = 0, `index`=6, `display`=7'b0000010, and `idx_out` slot 9 = 4.
- **Signed and ties.** All elements 16'h0005 except element 3 = 16'hFFFF (-1), `order`=1. Expect:
  - `index`=0.
  - `idx_out` slots 0..8 = 0,1,2,4,5,6,7,8,9.
  - Slot 9 = 3 with value 16'hFFFF.
- **Load while busy.** Pulse `load` with new data at accept+3. Expect it ignored, a single `complete` carrying the first result, and `busy` continuous.
- **Reset mid-sort.** Assert `rst` at accept+5. Expect no `complete`, all outputs at reset values with `display`=7'h7F, and a subsequent load to sort normally.
- **Back-to-back and parametrisation.** Hold `load` high for two sorts and expect `complete` pulses 11 cycles apart. Repeat the mixed case with N=16, W=8 and random vectors, checking the results against a reference model.
